// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin 2:1 arbiter feeding one registered output slot.
// Define MUX_RR_ARBITER_STATS_EN to add saturating per-requester accept counters.
module mux_rr_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y,
    output logic              y_src_o,
    input  logic              y_ready_i
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    input  logic              cnt_clr_i,
    output logic [15:0]       a_cnt_o,
    output logic [15:0]       b_cnt_o
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t            r_state;
    logic [1:0]        r_rst_sync;
    logic              r_last_a;
    logic              r_src;
    logic [DATA_W-1:0] r_y;
    logic              w_rst_n;
    logic              w_load;
    logic              w_win_a;
    logic              w_acc;

    // reset release is synchronised; readies stay low until it propagates
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_rst_sync <= 2'b00;
        else r_rst_sync <= {r_rst_sync[0], 1'b1};

    assign w_rst_n   = r_rst_sync[1];
    assign w_load    = w_rst_n & ((r_state == EMPTY) | y_ready_i);
    assign w_win_a   = a_valid_i & (~b_valid_i | ~r_last_a);
    assign a_ready_o = w_load & w_win_a;
    assign b_ready_o = w_load & b_valid_i & ~w_win_a;
    assign w_acc     = a_ready_o | b_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_state  <= EMPTY;
            r_y      <= '0;
            r_src    <= 1'b0;
            r_last_a <= 1'b0;
        end else if (w_acc) begin
            r_state  <= FULL;
            r_y      <= w_win_a ? a_i : b_i;
            r_src    <= w_win_a;
            r_last_a <= w_win_a;
        end else if (y_ready_i) begin
            r_state  <= EMPTY;
        end

    assign y_valid_o = (r_state == FULL);
    assign y         = r_y;
    assign y_src_o   = r_src;

`ifdef MUX_RR_ARBITER_STATS_EN
    logic [15:0] r_a_cnt;
    logic [15:0] r_b_cnt;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else begin
            if (a_ready_o && r_a_cnt != 16'hFFFF) r_a_cnt <= r_a_cnt + 16'd1;
            if (b_ready_o && r_b_cnt != 16'hFFFF) r_b_cnt <= r_b_cnt + 16'd1;
        end

    assign a_cnt_o = r_a_cnt;
    assign b_cnt_o = r_b_cnt;
`endif
endmodule
